vga_dither_out: RTL

//   Output stage between the demo pixel generator and the TinyVGA pin mapping.

---
 rtl/vga_dither_out.sv | 101 ++++++++++
 1 files changed

// File: rtl/vga_dither_out.sv
// Output stage to the TinyVGA pins: 4x4 Bayer dither of 6-bit colour down to 2 bits,
// with colour, blank and syncs all delayed by two pix_en strobes.
module vga_dither_out #(
  parameter bit DITHER_EN   = 1'b1,
  parameter bit TEMPORAL    = 1'b1,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [1:0] x_lsb,
  input  logic [1:0] y_lsb,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  input  logic       blank_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] frame
);

  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  logic [5:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic       blank1_q, blank1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d;
  logic [3:0] t1_q, t1_d;
  logic [1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d;
  logic [1:0] frame_q, frame_d;
  logic       vs_prev_q, vs_prev_d;
  logic [1:0] xi;
  logic [3:0] t_lut;

  // 3*63 only reaches 189, so full-scale input is pinned to level 3 explicitly.
  function automatic logic [1:0] quantise(input logic [5:0] c, input logic [3:0] t);
    logic [7:0] s;
    s = ({2'b00, c} * 8'd3) + ({4'b0000, t} << 2);
    if (!DITHER_EN) return c[5:4];
    if (c == 6'd63) return 2'd3;
    return s[7:6];
  endfunction

  always_comb begin
    xi = TEMPORAL ? 2'(x_lsb + frame_q) : x_lsb;
    t_lut = '0;
    case ({y_lsb, xi})
      4'h0: t_lut = 4'd0;   4'h1: t_lut = 4'd8;   4'h2: t_lut = 4'd2;   4'h3: t_lut = 4'd10;
      4'h4: t_lut = 4'd12;  4'h5: t_lut = 4'd4;   4'h6: t_lut = 4'd14;  4'h7: t_lut = 4'd6;
      4'h8: t_lut = 4'd3;   4'h9: t_lut = 4'd11;  4'ha: t_lut = 4'd1;   4'hb: t_lut = 4'd9;
      4'hc: t_lut = 4'd15;  4'hd: t_lut = 4'd7;   4'he: t_lut = 4'd13;  4'hf: t_lut = 4'd5;
      default: t_lut = '0;
    endcase
  end

  always_comb begin
    r1_d = r1_q;  g1_d = g1_q;  b1_d = b1_q;
    blank1_d = blank1_q;  hs1_d = hs1_q;  vs1_d = vs1_q;  t1_d = t1_q;
    r2_d = r2_q;  g2_d = g2_q;  b2_d = b2_q;  hs2_d = hs2_q;  vs2_d = vs2_q;
    frame_d = frame_q;  vs_prev_d = vs_prev_q;
    if (pix_en) begin
      r1_d = r_in;  g1_d = g_in;  b1_d = b_in;
      blank1_d = blank_in;  hs1_d = hsync_in;  vs1_d = vsync_in;  t1_d = t_lut;
      r2_d = blank1_q ? 2'd0 : quantise(r1_q, t1_q);
      g2_d = blank1_q ? 2'd0 : quantise(g1_q, t1_q);
      b2_d = blank1_q ? 2'd0 : quantise(b1_q, t1_q);
      hs2_d = hs1_q;  vs2_d = vs1_q;
      vs_prev_d = vsync_in;
      // Leading edge only: a held vsync pulse advances the frame once.
      if (vsync_in == SYNC_ACTIVE && vs_prev_q != SYNC_ACTIVE)
        frame_d = 2'(frame_q + 2'd1);
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;  g1_q <= '0;  b1_q <= '0;
      blank1_q <= 1'b0;  hs1_q <= SYNC_IDLE;  vs1_q <= SYNC_IDLE;  t1_q <= '0;
      r2_q <= '0;  g2_q <= '0;  b2_q <= '0;  hs2_q <= SYNC_IDLE;  vs2_q <= SYNC_IDLE;
      frame_q <= '0;  vs_prev_q <= SYNC_IDLE;
    end else begin
      r1_q <= r1_d;  g1_q <= g1_d;  b1_q <= b1_d;
      blank1_q <= blank1_d;  hs1_q <= hs1_d;  vs1_q <= vs1_d;  t1_q <= t1_d;
      r2_q <= r2_d;  g2_q <= g2_d;  b2_q <= b2_d;  hs2_q <= hs2_d;  vs2_q <= vs2_d;
      frame_q <= frame_d;  vs_prev_q <= vs_prev_d;
    end
  end

  assign r_out = r2_q;
  assign g_out = g2_q;
  assign b_out = b2_q;
  assign hsync = hs2_q;
  assign vsync = vs2_q;
  assign frame = frame_q;

endmodule
